// File: rtl/rotate_kick_unit.sv
// Rotate-and-kick unit: rotates the active piece about its pivot cell, then
// probes an ordered list of wall-kick offsets against the occupancy RAM and
// reports the first legal placement (or failure).

package rotate_kick_unit_pkg;
  typedef enum logic [2:0] {
    CYAN    = 3'd0,
    BLUE    = 3'd1,
    ORANGE  = 3'd2,
    YELLOW  = 3'd3,
    GREEN   = 3'd4,
    MAGENTA = 3'd5,
    RED     = 3'd6
  } block_color;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    ROT_RIGHT = 2'd1,
    ROT2      = 2'd2,
    ROT_LEFT  = 2'd3
  } orientation;
endpackage

module rotate_kick_unit
  import rotate_kick_unit_pkg::*;
#(
  parameter int unsigned COORD_W   = 5,
  parameter int unsigned BOARD_W   = 10,
  parameter int unsigned BOARD_H   = 20,
  parameter int unsigned NUM_KICKS = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 rot_req,
  input  logic                 rotate_left,
  input  block_color           block,
  input  orientation           cur_orientation,
  input  logic [4*COORD_W-1:0] x_block,
  input  logic [4*COORD_W-1:0] y_block,
  output logic                 occ_rd_en,
  output logic [COORD_W-1:0]   occ_x,
  output logic [COORD_W-1:0]   occ_y,
  input  logic                 occ_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic [4*COORD_W-1:0] new_x,
  output logic [4*COORD_W-1:0] new_y,
  output orientation           new_orientation
);

  localparam int unsigned KICK_W = 3;
  localparam int unsigned SLOT_W = 3;

  typedef logic [COORD_W-1:0]          coord_t;
  typedef logic [3:0][COORD_W-1:0]     cells_t;

  localparam coord_t POS1   = COORD_W'(1);
  localparam coord_t POS2   = COORD_W'(2);
  localparam coord_t NEG1   = '1;
  localparam coord_t LIM_X  = COORD_W'(BOARD_W);
  localparam coord_t LIM_Y  = COORD_W'(BOARD_H);
  localparam logic [KICK_W-1:0] LAST_KICK = KICK_W'(NUM_KICKS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(4);

  typedef enum logic [1:0] {IDLE, ROT, CHECK, DONE} state_t;

  state_t             state, state_nxt;
  cells_t             lat_x, lat_x_nxt, lat_y, lat_y_nxt;
  block_color         lat_color, lat_color_nxt;
  orientation         lat_orient, lat_orient_nxt;
  logic               lat_left, lat_left_nxt;
  cells_t             rot_x, rot_x_nxt, rot_y, rot_y_nxt;
  orientation         rot_orient, rot_orient_nxt;
  logic [KICK_W-1:0]  kick, kick_nxt;
  logic [SLOT_W-1:0]  slot, slot_nxt;
  logic               fail, fail_nxt;
  logic               rd_pend;
  logic               busy_nxt, done_nxt, success_nxt;
  logic               occ_rd_en_nxt;
  coord_t             occ_x_nxt, occ_y_nxt;
  cells_t             new_x_nxt, new_y_nxt;
  orientation         new_orient_nxt;

  cells_t             rx_c, ry_c;
  orientation         orient_c;
  coord_t             px, py, dx, dy, cor_x, cor_y;

  coord_t             kdx_cur, kdy_cur, kdx_nxt, kdy_nxt;
  coord_t             probe_x, probe_y;
  cells_t             kick_x_c, kick_y_c;
  logic               verdict_fail;

  // Fixed wall-kick offset table, returned as {dx, dy}
  function automatic logic [2*COORD_W-1:0] kick_offset(input logic [KICK_W-1:0] k);
    case (k)
      KICK_W'(1): kick_offset = {NEG1, coord_t'(0)};
      KICK_W'(2): kick_offset = {POS1, coord_t'(0)};
      KICK_W'(3): kick_offset = {coord_t'(0), NEG1};
      KICK_W'(4): kick_offset = {POS2, coord_t'(0)};
      default:    kick_offset = '0;
    endcase
  endfunction

  // Pivot rotation of the latched piece plus the I-piece correction
  always_comb begin
    px    = lat_x[1];
    py    = lat_y[1];
    dx    = '0;
    dy    = '0;
    cor_x = '0;
    cor_y = '0;
    rx_c  = '0;
    ry_c  = '0;
    if (lat_color == CYAN) begin
      if (lat_left) begin
        case (lat_orient)
          ROT_RIGHT: cor_x = NEG1;
          ROT2:      cor_y = NEG1;
          ROT_LEFT:  cor_x = POS1;
          default:   cor_y = POS1;
        endcase
      end else begin
        case (lat_orient)
          NORMAL:    cor_x = POS1;
          ROT_RIGHT: cor_y = POS1;
          ROT2:      cor_x = NEG1;
          default:   cor_y = NEG1;
        endcase
      end
    end
    for (int i = 0; i < 4; i++) begin
      dx = lat_x[i] - px;
      dy = lat_y[i] - py;
      if (lat_left) begin
        rx_c[i] = px + dy + cor_x;
        ry_c[i] = py - dx + cor_y;
      end else begin
        rx_c[i] = px - dy + cor_x;
        ry_c[i] = py + dx + cor_y;
      end
    end
    orient_c = lat_left ? orientation'(2'(lat_orient) - 2'd1)
                        : orientation'(2'(lat_orient) + 2'd1);
  end

  // Rotated cells shifted by the kick currently under test
  always_comb begin
    {kdx_cur, kdy_cur} = kick_offset(kick);
    for (int i = 0; i < 4; i++) begin
      kick_x_c[i] = rot_x[i] + kdx_cur;
      kick_y_c[i] = rot_y[i] + kdy_cur;
    end
    verdict_fail = fail | (rd_pend & occ_rd_data);
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt      = state;
    lat_x_nxt      = lat_x;
    lat_y_nxt      = lat_y;
    lat_color_nxt  = lat_color;
    lat_orient_nxt = lat_orient;
    lat_left_nxt   = lat_left;
    rot_x_nxt      = rot_x;
    rot_y_nxt      = rot_y;
    rot_orient_nxt = rot_orient;
    kick_nxt       = kick;
    slot_nxt       = slot;
    fail_nxt       = fail;
    success_nxt    = success;
    new_x_nxt      = cells_t'(new_x);
    new_y_nxt      = cells_t'(new_y);
    new_orient_nxt = new_orientation;
    occ_rd_en_nxt  = 1'b0;
    occ_x_nxt      = occ_x;
    occ_y_nxt      = occ_y;
    kdx_nxt        = '0;
    kdy_nxt        = '0;
    probe_x        = '0;
    probe_y        = '0;

    case (state)
      IDLE: begin
        if (rot_req) begin
          lat_x_nxt      = cells_t'(x_block);
          lat_y_nxt      = cells_t'(y_block);
          lat_color_nxt  = block;
          lat_orient_nxt = cur_orientation;
          lat_left_nxt   = rotate_left;
          state_nxt      = ROT;
        end
      end
      ROT: begin
        rot_x_nxt      = rx_c;
        rot_y_nxt      = ry_c;
        rot_orient_nxt = orient_c;
        if (lat_color == YELLOW) begin
          state_nxt      = DONE;
          success_nxt    = 1'b1;
          new_x_nxt      = lat_x;
          new_y_nxt      = lat_y;
          new_orient_nxt = lat_orient;
        end else begin
          state_nxt = CHECK;
          kick_nxt  = '0;
          slot_nxt  = '0;
          fail_nxt  = 1'b0;
        end
      end
      CHECK: begin
        if (slot != LAST_SLOT) begin
          slot_nxt = slot + SLOT_W'(1);
          fail_nxt = verdict_fail;
        end else if (!verdict_fail) begin
          state_nxt      = DONE;
          success_nxt    = 1'b1;
          new_x_nxt      = kick_x_c;
          new_y_nxt      = kick_y_c;
          new_orient_nxt = rot_orient;
        end else if (kick == LAST_KICK) begin
          state_nxt      = DONE;
          success_nxt    = 1'b0;
          new_x_nxt      = lat_x;
          new_y_nxt      = lat_y;
          new_orient_nxt = lat_orient;
        end else begin
          kick_nxt = kick + KICK_W'(1);
          slot_nxt = '0;
          fail_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Issue slot for the next cycle: bounds check or occupancy read
    if ((state_nxt == CHECK) && (slot_nxt != LAST_SLOT)) begin
      {kdx_nxt, kdy_nxt} = kick_offset(kick_nxt);
      probe_x = rot_x_nxt[slot_nxt[1:0]] + kdx_nxt;
      probe_y = rot_y_nxt[slot_nxt[1:0]] + kdy_nxt;
      if ((probe_x >= LIM_X) || (probe_y >= LIM_Y)) begin
        fail_nxt = 1'b1;
      end else begin
        occ_rd_en_nxt = 1'b1;
        occ_x_nxt     = probe_x;
        occ_y_nxt     = probe_y;
      end
    end

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      lat_x           <= '0;
      lat_y           <= '0;
      lat_color       <= CYAN;
      lat_orient      <= NORMAL;
      lat_left        <= 1'b0;
      rot_x           <= '0;
      rot_y           <= '0;
      rot_orient      <= NORMAL;
      kick            <= '0;
      slot            <= '0;
      fail            <= 1'b0;
      rd_pend         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      success         <= 1'b0;
      occ_rd_en       <= 1'b0;
      occ_x           <= '0;
      occ_y           <= '0;
      new_x           <= '0;
      new_y           <= '0;
      new_orientation <= NORMAL;
    end else begin
      state           <= state_nxt;
      lat_x           <= lat_x_nxt;
      lat_y           <= lat_y_nxt;
      lat_color       <= lat_color_nxt;
      lat_orient      <= lat_orient_nxt;
      lat_left        <= lat_left_nxt;
      rot_x           <= rot_x_nxt;
      rot_y           <= rot_y_nxt;
      rot_orient      <= rot_orient_nxt;
      kick            <= kick_nxt;
      slot            <= slot_nxt;
      fail            <= fail_nxt;
      rd_pend         <= occ_rd_en;
      busy            <= busy_nxt;
      done            <= done_nxt;
      success         <= success_nxt;
      occ_rd_en       <= occ_rd_en_nxt;
      occ_x           <= occ_x_nxt;
      occ_y           <= occ_y_nxt;
      new_x           <= new_x_nxt;
      new_y           <= new_y_nxt;
      new_orientation <= new_orient_nxt;
    end
  end

endmodule
